alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe.sv | 165 ++++++++++++++++
 tb/tb_alu_pipe.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Single-issue ALU with one output register; optional iterative multiplier under ALU_PIPE_MUL_EN.
// Latency: 1 cycle for ops 0-6; MUL is OPERAND_SIZE+1 cycles, or 1 cycle returning 0 when ALU_PIPE_MUL_EN is undefined.
// Backpressure: in_ready drops while a result waits for out_ready, while MUL_BUSY, or during flush.
module alu_pipe #(
    parameter int OPERAND_SIZE     = 32,
    parameter int REG_ADDRESS_SIZE = 5
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        flush,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [2:0]                  in_op,
    input  logic [OPERAND_SIZE-1:0]     in_operand1,
    input  logic [OPERAND_SIZE-1:0]     in_operand2,
    input  logic [REG_ADDRESS_SIZE:0]   in_static,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [OPERAND_SIZE-1:0]     out_result,
    output logic                        out_zero,
    output logic [REG_ADDRESS_SIZE:0]   out_static
);

    localparam int SHW = $clog2(OPERAND_SIZE);
    localparam int STW = REG_ADDRESS_SIZE + 1;

    typedef enum logic [2:0] {
        OP_ADD = 3'd0,
        OP_SUB = 3'd1,
        OP_AND = 3'd2,
        OP_OR  = 3'd3,
        OP_XOR = 3'd4,
        OP_SLT = 3'd5,
        OP_SLL = 3'd6,
        OP_MUL = 3'd7
    } op_e;

    typedef struct packed {
        logic [OPERAND_SIZE-1:0] result;
        logic [STW-1:0]          stat;
    } out_t;

    out_t                    out_q;
    out_t                    load_dat;
    logic                    out_vld_q;
    logic                    out_free;
    logic                    accept;
    logic                    load;
    logic                    slt_bit;
    logic [OPERAND_SIZE-1:0] alu_res;

    assign out_free = !out_vld_q || out_ready;
    assign accept   = in_valid && in_ready;
    assign slt_bit  = $signed(in_operand1) < $signed(in_operand2);

    always_comb begin
        alu_res = '0;
        case (op_e'(in_op))
            OP_ADD:  alu_res = in_operand1 + in_operand2;
            OP_SUB:  alu_res = in_operand1 - in_operand2;
            OP_AND:  alu_res = in_operand1 & in_operand2;
            OP_OR:   alu_res = in_operand1 | in_operand2;
            OP_XOR:  alu_res = in_operand1 ^ in_operand2;
            OP_SLT:  alu_res = {{(OPERAND_SIZE-1){1'b0}}, slt_bit};
            OP_SLL:  alu_res = in_operand1 << in_operand2[SHW-1:0];
            default: alu_res = '0;
        endcase
    end

`ifdef ALU_PIPE_MUL_EN
    typedef enum logic {
        IDLE     = 1'b0,
        MUL_BUSY = 1'b1
    } state_e;

    state_e                  state_q;
    state_e                  state_d;
    logic [OPERAND_SIZE-1:0] mcand_q;
    logic [OPERAND_SIZE-1:0] mplier_q;
    logic [OPERAND_SIZE-1:0] acc_q;
    logic [OPERAND_SIZE-1:0] acc_step;
    logic [SHW-1:0]          cnt_q;
    logic [STW-1:0]          mul_stat_q;
    logic                    mul_start;
    logic                    mul_last;
    logic                    mul_stall;
    logic                    mul_done;

    assign in_ready  = (state_q == IDLE) && out_free && !flush;
    assign mul_start = accept && (op_e'(in_op) == OP_MUL);
    assign acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
    assign mul_last  = (cnt_q == SHW'(OPERAND_SIZE - 1));
    // The last partial product is folded straight into the output load, so
    // finishing has to wait for a free output register rather than overwrite it.
    assign mul_stall = mul_last && !out_free;
    assign mul_done  = (state_q == MUL_BUSY) && mul_last && out_free && !flush;

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:     if (mul_start) state_d = MUL_BUSY;
            MUL_BUSY: if (mul_done)  state_d = IDLE;
            default:  state_d = IDLE;
        endcase
        if (flush) state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mcand_q    <= '0;
            mplier_q   <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            mul_stat_q <= '0;
        end else if (flush) begin
            cnt_q <= '0;
        end else if (mul_start) begin
            mcand_q    <= in_operand1;
            mplier_q   <= in_operand2;
            acc_q      <= '0;
            cnt_q      <= '0;
            mul_stat_q <= in_static;
        end else if ((state_q == MUL_BUSY) && !mul_stall) begin
            // Counter wraps to zero on the final step since OPERAND_SIZE is a power of two.
            acc_q    <= acc_step;
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + SHW'(1);
        end
    end

    assign load     = (accept && !mul_start) || mul_done;
    assign load_dat = mul_done ? '{result: acc_step, stat: mul_stat_q}
                               : '{result: alu_res,  stat: in_static};
`else
    assign in_ready = out_free && !flush;
    assign load     = accept;
    assign load_dat = '{result: alu_res, stat: in_static};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_vld_q <= 1'b0;
            out_q     <= '0;
        end else if (flush) begin
            out_vld_q <= 1'b0;
        end else if (load) begin
            out_vld_q <= 1'b1;
            out_q     <= load_dat;
        end else if (out_ready) begin
            out_vld_q <= 1'b0;
        end
    end

    assign out_valid  = out_vld_q;
    assign out_result = out_q.result;
    assign out_static = out_q.stat;
    assign out_zero   = (out_q.result == '0);

endmodule

// File: tb/tb_alu_pipe.sv
// Directed bench for alu_pipe: scoreboard of expected results checked at each output handshake,
// plus timing, backpressure, flush and reset checks.
module tb_alu_pipe;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  in_op;
    logic [31:0] in_operand1;
    logic [31:0] in_operand2;
    logic [5:0]  in_static;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_result;
    logic        out_zero;
    logic [5:0]  out_static;

    typedef struct {
        logic [31:0] res;
        logic [5:0]  st;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    alu_pipe #(.OPERAND_SIZE(32), .REG_ADDRESS_SIZE(5)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush       (flush),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_operand1 (in_operand1),
        .in_operand2 (in_operand2),
        .in_static   (in_static),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_result  (out_result),
        .out_zero    (out_zero),
        .out_static  (out_static)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Drive one request from just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [5:0] st, input bit track, input logic [31:0] exp_res);
        in_valid    = 1'b1;
        in_op       = op;
        in_operand1 = a;
        in_operand2 = b;
        in_static   = st;
        @(negedge clk);
        chk("accept_ready", in_ready, 1);
        if (track) sb.push_back('{res: exp_res, st: st});
        @(posedge clk);
        #1;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            chk("sb_nonempty", sb.size() > 0, 1);
            if (sb.size() > 0) begin
                exp_t e;
                e = sb.pop_front();
                chk("out_result", out_result, e.res);
                chk("out_static", out_static, e.st);
                chk("out_zero", out_zero, e.res == 32'h0);
            end
        end
    end

    initial begin
        int lat;
        int lowcnt;
        int spurious;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_op = 3'd0;
        in_operand1 = '0; in_operand2 = '0; in_static = '0; out_ready = 1'b1;

        #12;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out_result", out_result, 0);
        chk("rst_out_zero", out_zero, 1);
        chk("rst_out_static", out_static, 0);
        chk("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // ADD wrap to zero on the first edge after reset release
        send(3'd0, 32'hFFFF_FFFF, 32'h1, 6'h2A, 1, 32'h0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("add_lat1_valid", out_valid, 1);
        chk("add_zero", out_zero, 1);
        step(1);

        // back-to-back single-cycle ops; each send re-checks in_ready while a result is out
        send(3'd1, 32'd5, 32'd7, 6'h03, 1, 32'hFFFF_FFFE);
        send(3'd5, 32'hFFFF_FFFF, 32'd1, 6'h04, 1, 32'd1);
        send(3'd5, 32'd1, 32'hFFFF_FFFF, 6'h05, 1, 32'd0);
        send(3'd6, 32'd1, 32'h24, 6'h06, 1, 32'h10);
        send(3'd2, 32'hF0F0, 32'h0FF0, 6'h07, 1, 32'h00F0);
        send(3'd3, 32'hF0F0, 32'h0FF0, 6'h08, 1, 32'hFFF0);
        send(3'd4, 32'h1234_5678, 32'hFFFF_0000, 6'h09, 1, 32'hEDCB_5678);
        in_valid = 1'b0;
        step(1);

        // output held under backpressure, next request waits
        out_ready = 1'b0;
        send(3'd0, 32'd3, 32'd4, 6'h0A, 1, 32'd7);
        in_valid = 1'b1; in_op = 3'd0; in_operand1 = 32'd1; in_operand2 = 32'd1; in_static = 6'h0B;
        repeat (3) begin
            @(negedge clk);
            chk("stall_in_ready", in_ready, 0);
            chk("stall_hold_result", out_result, 7);
            chk("stall_hold_static", out_static, 6'h0A);
            chk("stall_hold_valid", out_valid, 1);
            step(1);
        end
        out_ready = 1'b1;
        send(3'd0, 32'd1, 32'd1, 6'h0B, 1, 32'd2);
        in_valid = 1'b0;
        step(1);

`ifdef ALU_PIPE_MUL_EN
        send(3'd7, 32'h0001_0000, 32'h0001_0001, 6'h15, 1, 32'h0001_0000);
        in_valid = 1'b1;
        in_op = 3'd0;
        lat = 1;
        lowcnt = 0;
        forever begin
            @(negedge clk);
            if (out_valid || lat >= 100) break;
            if (!in_ready) lowcnt++;
            step(1);
            lat++;
        end
        chk("mul_latency", lat, 33);
        chk("mul_in_ready_low", lowcnt, 32);
        in_valid = 1'b0;
        step(1);

        // flush in cycle N+10 aborts the multiply
        send(3'd7, 32'd3, 32'd5, 6'h16, 0, 32'd0);
        in_valid = 1'b0;
        step(9);
        flush = 1'b1;
        step(1);
        flush = 1'b0;
        @(negedge clk);
        chk("mul_flush_in_ready", in_ready, 1);
        chk("mul_flush_valid", out_valid, 0);
        spurious = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) spurious++;
        end
        chk("mul_flush_no_result", spurious, 0);
        step(1);
`else
        send(3'd7, 32'd6, 32'd7, 6'h11, 1, 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("mul_off_valid", out_valid, 1);
        chk("mul_off_zero", out_zero, 1);
        step(1);

        // flush drops a held result and blocks a concurrent request
        out_ready = 1'b0;
        send(3'd4, 32'hF0, 32'hFF, 6'h12, 0, 32'd0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("flush_pre_result", out_result, 32'h0F);
        flush = 1'b1;
        in_valid = 1'b1; in_op = 3'd0; in_operand1 = 32'd9; in_operand2 = 32'd9; in_static = 6'h13;
        #1;
        chk("flush_in_ready", in_ready, 0);
        step(1);
        flush = 1'b0;
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        chk("flush_valid_cleared", out_valid, 0);
        step(1);
`endif

        // asynchronous reset mid-cycle returns outputs to reset values at once
        send(3'd3, 32'h5, 32'hA, 6'h21, 1, 32'hF);
`ifdef ALU_PIPE_MUL_EN
        send(3'd7, 32'd3, 32'd5, 6'h22, 0, 32'd0);
`endif
        in_valid = 1'b0;
        step(5);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_out_valid", out_valid, 0);
        chk("arst_out_result", out_result, 0);
        chk("arst_out_zero", out_zero, 1);
        chk("arst_out_static", out_static, 0);
        chk("arst_in_ready", in_ready, 1);
        step(1);
        rst_n = 1'b1;
        spurious = 0;
        repeat (40) begin
            @(negedge clk);
            if (out_valid) spurious++;
        end
        chk("arst_no_result", spurious, 0);
        chk("sb_drained", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
